// File: rtl/dmem_router4.sv
// rtl/dmem_router4.sv - 1-to-4 data-memory request router with timeout
//
// Routes one core load/store at a time to one of four targets chosen by the
// two top address bits (0=DMEM, 1=IO, 2=TIMER, 3=spare). It returns read data
// or a store completion as a single-cycle rsp_valid pulse. If the target does
// not respond in time, the core gets rsp_err=1 instead of waiting forever.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid/ready      core request handshake (ready only in IDLE)
//   req_we/addr/wdata    core request fields
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata/err        load data (0 for stores/errors), timeout flag
//   t_valid[3:0]         one-hot request strobe to the selected target
//   t_ready[3:0]         per-target request accept
//   t_we/addr/wdata      latched request fields, shared by all targets
//   t_rvalid[3:0]        per-target read data valid
//   t_rdata              packed read data, target i at [i*WIDTH +: WIDTH]
module dmem_router4 #(
  parameter int WIDTH   = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic [3:0]           t_valid,
  input  logic [3:0]           t_ready,
  output logic                 t_we,
  output logic [AW-1:0]        t_addr,
  output logic [WIDTH-1:0]     t_wdata,
  input  logic [3:0]           t_rvalid,
  input  logic [4*WIDTH-1:0]   t_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          sel_d   = req_addr[AW-1 -: 2];
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A handshake in the final counted cycle still wins over the timeout.
        if (t_ready[sel_q]) begin
          if (we_q) begin
            err_d   = 1'b0;
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_RSP;
          end
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RSP: begin
        if (t_rvalid[sel_q]) begin
          rdata_d = t_rdata[int'(sel_q)*WIDTH +: WIDTH];
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs: everything below depends only on registered state.
  always_comb begin
    t_valid = 4'b0000;
    if (state_q == S_REQ) t_valid[sel_q] = 1'b1;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign t_we      = we_q;
  assign t_addr    = addr_q;
  assign t_wdata   = wdata_q;

endmodule

// File: tb/tb_dmem_router4.sv
// tb/tb_dmem_router4.sv - testbench for dmem_router4
module tb_dmem_router4;

  localparam int T = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   t_valid;
  logic [3:0]   t_ready;
  logic         t_we;
  logic [31:0]  t_addr;
  logic [31:0]  t_wdata;
  logic [3:0]   t_rvalid;
  logic [127:0] t_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_router4 #(.WIDTH(32), .AW(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .t_valid(t_valid), .t_ready(t_ready), .t_we(t_we), .t_addr(t_addr),
    .t_wdata(t_wdata), .t_rvalid(t_rvalid), .t_rdata(t_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction. Outcome is predicted from the target's behaviour:
  // t_ready[sel] rises rd cycles into REQ, t_rvalid[sel] rises rvd cycles
  // into RSP; a wait longer than T cycles ends in an error response.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int rd, input int rvd, input bit noise, input bit early_rv,
                         input bit hold_next, input logic n_we, input logic [31:0] n_addr,
                         input logic [31:0] n_wdata, output int waited);
    int sel, req_last, rsp_cyc, rsp_start;
    bit to;
    logic [31:0] exp_rd;
    logic [3:0] oh, tr, rv;
    sel = int'(addr[31:30]);
    oh = 4'b0001 << sel;
    rsp_start = rd + 2;
    if (rd > T) begin
      to = 1'b1; req_last = T + 1; rsp_cyc = T + 2;
    end else if (we) begin
      to = 1'b0; req_last = rd + 1; rsp_cyc = rd + 2;
    end else if (rvd > T) begin
      to = 1'b1; req_last = rd + 1; rsp_cyc = rsp_start + T + 1;
    end else begin
      to = 1'b0; req_last = rd + 1; rsp_cyc = rsp_start + rvd + 1;
    end
    exp_rd = (we || to) ? 32'h0 : rdata;

    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    t_ready = 4'b0000; t_rvalid = 4'b0000;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      $display("FAIL %s accept: req_ready=%b required 1 within 50 cycles", name, req_ready);
      n_fail++;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold_next) begin
      req_we = n_we; req_addr = n_addr; req_wdata = n_wdata;
    end else begin
      req_valid = 1'b0;
    end

    for (int k = 1; k <= rsp_cyc + 1; k++) begin
      @(negedge clk);
      tr = noise ? (4'($urandom) & ~oh) : 4'b0000;
      rv = noise ? (4'($urandom) & ~oh) : 4'b0000;
      if (rd <= T && k >= rd + 1) tr = tr | oh;
      if (!we && rd <= T && k >= rsp_start + rvd) rv = rv | oh;
      if (early_rv && k <= req_last) rv = rv | oh;
      t_ready = tr;
      t_rvalid = rv;
      for (int i = 0; i < 4; i++) t_rdata[i*32 +: 32] = (i == sel) ? rdata : 32'hFFFF_FFFF;

      n_tests++;
      if (t_valid !== ((k <= req_last) ? oh : 4'b0000)) begin
        $display("FAIL %s t_valid cyc%0d: got %b required %b", name, k, t_valid,
                 (k <= req_last) ? oh : 4'b0000);
        n_fail++;
      end
      n_tests++;
      if (rsp_valid !== (k == rsp_cyc)) begin
        $display("FAIL %s rsp_valid cyc%0d: got %b required %b", name, k, rsp_valid, k == rsp_cyc);
        n_fail++;
      end
      n_tests++;
      if (req_ready !== (k == rsp_cyc + 1)) begin
        $display("FAIL %s req_ready cyc%0d: got %b required %b", name, k, req_ready, k == rsp_cyc + 1);
        n_fail++;
      end
      if (k <= req_last) begin
        n_tests++;
        if (t_addr !== addr || t_we !== we || t_wdata !== wdata) begin
          $display("FAIL %s t_fields cyc%0d: got %b/%h/%h required %b/%h/%h", name, k,
                   t_we, t_addr, t_wdata, we, addr, wdata);
          n_fail++;
        end
      end
      if (k == rsp_cyc) begin
        n_tests++;
        if (rsp_err !== to) begin
          $display("FAIL %s rsp_err: got %b required %b", name, rsp_err, to);
          n_fail++;
        end
      end
      if (k >= rsp_cyc) begin
        n_tests++;
        if (rsp_rdata !== exp_rd) begin
          $display("FAIL %s rsp_rdata cyc%0d: got %h required %h", name, k, rsp_rdata, exp_rd);
          n_fail++;
        end
      end
    end
    t_ready = 4'b0000;
    t_rvalid = 4'b0000;
  endtask

  task automatic test_reset();
    int w;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    t_ready = '0; t_rvalid = '0; t_rdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || t_valid !== 4'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'h0 || t_addr !== 32'h0 || t_we !== 1'b0 || t_wdata !== 32'h0) begin
      $display("FAIL reset_values: rdy=%b tv=%b rv=%b err=%b rd=%h ta=%h twe=%b twd=%h required 1/0/0/0/0/0/0/0",
               req_ready, t_valid, rsp_valid, rsp_err, rsp_rdata, t_addr, t_we, t_wdata);
      n_fail++;
    end
    // Abort a stalled request with a two-cycle reset.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0100; req_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (t_valid !== 4'b0010) begin
      $display("FAIL reset_pre t_valid: got %b required 0010", t_valid);
      n_fail++;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (t_valid !== 4'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        $display("FAIL reset_abort: tv=%b rdy=%b rv=%b required 0000/1/0", t_valid, req_ready, rsp_valid);
        n_fail++;
      end
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || t_valid !== 4'b0 || t_addr !== 32'h0) begin
        $display("FAIL reset_quiet: rv=%b tv=%b ta=%h required 0/0000/0", rsp_valid, t_valid, t_addr);
        n_fail++;
      end
    end
    w = 0;
  endtask

  task automatic test_store();
    int w;
    run_txn("store", 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, w);
  endtask

  task automatic test_load();
    int w;
    run_txn("load", 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, w);
  endtask

  task automatic test_timeout();
    int w;
    run_txn("timeout_req", 1'b0, 32'hC000_0000, 32'h0, 32'h5555_AAAA, T + 10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, w);
    run_txn("timeout_rsp", 1'b0, 32'h8000_0040, 32'h0, 32'h7777_1111, 2, T + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, w);
  endtask

  task automatic test_boundary();
    int w;
    run_txn("edge_req_hs", 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'h0, T, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, w);
    run_txn("edge_req_to", 1'b1, 32'h4000_0004, 32'h0BAD_F00D, 32'h0, T + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, w);
    run_txn("edge_rsp_hs", 1'b0, 32'hC000_0008, 32'h0, 32'hCAFE_0001, 0, T, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, w);
  endtask

  task automatic test_noise();
    int w;
    run_txn("noise", 1'b0, 32'h8000_0000, 32'h0, 32'h0102_0304, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, w);
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    run_txn("b2b_first", 1'b1, 32'h4000_0200, 32'h1111_2222, 32'h0, 1, 0, 1'b0, 1'b0,
            1'b1, 1'b0, 32'h8000_0300, 32'h0, w1);
    run_txn("b2b_second", 1'b0, 32'h8000_0300, 32'h0, 32'h3333_4444, 0, 0, 1'b0, 1'b0,
            1'b0, 1'b0, 0, 0, w2);
    n_tests++;
    if (w2 !== 0) begin
      $display("FAIL b2b_accept_wait: got %0d cycles required 0", w2);
      n_fail++;
    end
  endtask

  task automatic test_random();
    int w, rd, rvd;
    for (int n = 0; n < 25; n++) begin
      rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 3);
      rvd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 3);
      run_txn("random", 1'($urandom), $urandom, $urandom, $urandom, rd, rvd,
              1'($urandom), 1'($urandom), 1'b0, 1'b0, 0, 0, w);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_timeout();
    test_boundary();
    test_noise();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
